// File: rtl/keypad_code_lock.sv
// rtl/keypad_code_lock.sv - keypad debouncer, PIN entry register and code-check lock FSM
module keypad_code_lock #(
   parameter int                  DIGITS      = 4,
   parameter logic [4*DIGITS-1:0] PASSWORD    = 16'h1234,
   parameter int                  STABLE_CYC  = 16,
   parameter int                  RELEASE_CYC = 16,
   parameter int                  MAX_FAIL    = 3,
   parameter int                  LOCKOUT_CYC = 1000,
   parameter int                  OPEN_CYC    = 5000
) (
   input  logic                         sys_clk,
   input  logic                         sys_rst_n,
   input  logic [3:0]                   key_code,
   output logic                         key_valid,
   output logic [3:0]                   key_val,
   output logic [4*DIGITS-1:0]          entry,
   output logic [$clog2(DIGITS+1)-1:0]  digit_cnt,
   output logic                         unlocked,
   output logic                         fail,
   output logic                         alarm
);

   localparam int SW   = $clog2(STABLE_CYC + 1);
   localparam int RW   = $clog2(RELEASE_CYC + 1);
   localparam int FW   = $clog2(MAX_FAIL + 1);
   localparam int CW   = $clog2(DIGITS + 1);
   localparam int TMAX = (OPEN_CYC > LOCKOUT_CYC) ? OPEN_CYC : LOCKOUT_CYC;
   localparam int TW   = $clog2(TMAX + 1);

   localparam logic [3:0]    K_IDLE    = 4'hF;
   localparam logic [3:0]    K_CLR     = 4'hA;
   localparam logic [3:0]    K_ZERO    = 4'hB;
   localparam logic [3:0]    K_ENT     = 4'hC;
   localparam logic [SW-1:0] STABLE_V  = SW'(STABLE_CYC);
   localparam logic [RW-1:0] RELEASE_V = RW'(RELEASE_CYC);
   localparam logic [FW-1:0] FAIL_V    = FW'(MAX_FAIL);
   localparam logic [CW-1:0] DIGITS_V  = CW'(DIGITS);
   // Timers count down to zero, so the load is one less than the dwell time.
   localparam logic [TW-1:0] OPEN_LOAD = TW'(OPEN_CYC - 1);
   localparam logic [TW-1:0] LOCK_LOAD = TW'(LOCKOUT_CYC - 1);

   typedef enum logic [1:0] {
      ST_ENTRY = 2'd0,
      ST_OPEN  = 2'd1,
      ST_ALARM = 2'd2
   } state_t;

   // Debouncer state
   logic [3:0]    cand_q;
   logic [SW-1:0] stab_q, stab_d;
   logic [RW-1:0] rel_q, rel_d;
   logic          armed_q, armed_d;
   logic          key_valid_d;
   logic [3:0]    key_val_d;

   // Lock state
   state_t                state_q, state_d;
   logic [4*DIGITS-1:0]   entry_d;
   logic [CW-1:0]         digit_cnt_d;
   logic [FW-1:0]         fail_cnt_q, fail_cnt_d;
   logic [TW-1:0]         timer_q, timer_d;
   logic                  fail_d;
   logic                  is_digit;
   logic [3:0]            bcd;

   // Debouncer next state: the stability count includes the sample that started the run
   always_comb begin
      stab_d      = stab_q;
      rel_d       = rel_q;
      armed_d     = armed_q;
      key_valid_d = 1'b0;
      key_val_d   = key_val;
      if (key_code != cand_q) begin
         stab_d = (key_code == K_IDLE) ? '0 : SW'(1);
      end else if (key_code != K_IDLE && stab_q != STABLE_V) begin
         stab_d = stab_q + 1'b1;
      end
      if (key_code == K_IDLE) begin
         rel_d = (rel_q == RELEASE_V) ? rel_q : rel_q + 1'b1;
      end else begin
         rel_d = '0;
      end
      if (key_code == K_IDLE && rel_d == RELEASE_V) begin
         armed_d = 1'b1;
      end
      if (key_code != K_IDLE && stab_d == STABLE_V && armed_q) begin
         armed_d = 1'b0;
         if (key_code >= 4'h1 && key_code <= K_ENT) begin
            key_valid_d = 1'b1;
            key_val_d   = key_code;
         end
      end
   end

   // Debouncer registers
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         cand_q    <= K_IDLE;
         stab_q    <= '0;
         rel_q     <= '0;
         armed_q   <= 1'b1;
         key_valid <= 1'b0;
         key_val   <= 4'h0;
      end else begin
         cand_q    <= key_code;
         stab_q    <= stab_d;
         rel_q     <= rel_d;
         armed_q   <= armed_d;
         key_valid <= key_valid_d;
         key_val   <= key_val_d;
      end
   end

   // Lock FSM next state: acts on the registered key event; timer expiry beats any key
   always_comb begin
      state_d     = state_q;
      entry_d     = entry;
      digit_cnt_d = digit_cnt;
      fail_cnt_d  = fail_cnt_q;
      timer_d     = timer_q;
      fail_d      = 1'b0;
      is_digit    = (key_val >= 4'h1 && key_val <= 4'h9) || (key_val == K_ZERO);
      bcd         = (key_val == K_ZERO) ? 4'h0 : key_val;
      case (state_q)
         ST_ENTRY: begin
            if (key_valid) begin
               if (is_digit) begin
                  if (digit_cnt < DIGITS_V) begin
                     entry_d     = {entry[4*DIGITS-5:0], bcd};
                     digit_cnt_d = digit_cnt + 1'b1;
                  end
               end else if (key_val == K_CLR) begin
                  entry_d     = '0;
                  digit_cnt_d = '0;
               end else if (key_val == K_ENT) begin
                  entry_d     = '0;
                  digit_cnt_d = '0;
                  if (digit_cnt == DIGITS_V && entry == PASSWORD) begin
                     state_d    = ST_OPEN;
                     fail_cnt_d = '0;
                     timer_d    = OPEN_LOAD;
                  end else begin
                     fail_d     = 1'b1;
                     fail_cnt_d = (fail_cnt_q == FAIL_V) ? fail_cnt_q : fail_cnt_q + 1'b1;
                     if (fail_cnt_d == FAIL_V) begin
                        state_d = ST_ALARM;
                        timer_d = LOCK_LOAD;
                     end
                  end
               end
            end
         end
         ST_OPEN: begin
            if (timer_q == '0) begin
               state_d = ST_ENTRY;
            end else begin
               timer_d = timer_q - 1'b1;
               if (key_valid && (key_val == K_CLR || key_val == K_ENT)) begin
                  state_d = ST_ENTRY;
               end
            end
         end
         ST_ALARM: begin
            if (timer_q == '0) begin
               state_d    = ST_ENTRY;
               fail_cnt_d = '0;
            end else begin
               timer_d = timer_q - 1'b1;
            end
         end
         default: state_d = ST_ENTRY;
      endcase
   end

   // Lock registers; status outputs are registered from the next state
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q    <= ST_ENTRY;
         entry      <= '0;
         digit_cnt  <= '0;
         fail_cnt_q <= '0;
         timer_q    <= '0;
         fail       <= 1'b0;
         unlocked   <= 1'b0;
         alarm      <= 1'b0;
      end else begin
         state_q    <= state_d;
         entry      <= entry_d;
         digit_cnt  <= digit_cnt_d;
         fail_cnt_q <= fail_cnt_d;
         timer_q    <= timer_d;
         fail       <= fail_d;
         unlocked   <= (state_d == ST_OPEN);
         alarm      <= (state_d == ST_ALARM);
      end
   end

endmodule

// File: doc/keypad_code_lock.md
# keypad_code_lock

Digit-entry and code-check stage directly downstream of the keypad scanner. It consumes the scanner's 4-bit held key code, where 4'hF means no key. It debounces the code into single key events and assembles digits into an entry register. It compares the entry against a parameterised PIN and drives unlock, fail and lockout-alarm status for the display and LED stages.

## Interface
- DIGITS, 4: PIN length in digits; entry width is 4*DIGITS.
- PASSWORD, 16'h1234: expected PIN, one BCD digit per nibble, first-entered digit in the MS nibble.
- STABLE_CYC, 16: consecutive identical non-F samples required to accept a press.
- RELEASE_CYC, 16: consecutive 4'hF samples required to re-arm after a press.
- MAX_FAIL, 3: wrong ENT attempts that trigger ALARM.
- LOCKOUT_CYC, 1000: ALARM duration in cycles.
- OPEN_CYC, 5000: cycles in OPEN before auto-relock.
- sys_clk, input, 1: clock.
- sys_rst_n, input, 1: reset; asynchronous, active-low.
- key_code, input, 4: scanner code. Digits map as 1–9 to 4'h1–4'h9 and 0 to 4'hB. 4'hA is CLR, 4'hC is ENT, 4'hF is idle.
- key_valid, output, 1: one-cycle pulse for each accepted press.
- key_val, output, 4: code accepted with the latest key_valid; held until the next one.
- entry, output, 4*DIGITS: digits entered so far, newest in the LS nibble.
- digit_cnt, output, clog2(DIGITS+1): number of digits in entry.
- unlocked, output, 1: high in OPEN.
- fail, output, 1: one-cycle pulse on a rejected ENT.
- alarm, output, 1: high in ALARM.

## Operation
- Reset values: key_valid=0, key_val=0, entry=0, digit_cnt=0, unlocked=0, fail=0, alarm=0. Internal reset: state=ENTRY, fail_cnt=0, cand=4'hF, armed=1, counters=0.
- Debouncer:
  - cand holds the last sample. If key_code differs from cand: cand<=key_code and the stability counter clears.
  - While key_code==cand!=F, the counter increments and saturates.
  - When the count reaches STABLE_CYC and armed=1: key_valid pulses only if cand is in 4'h1..4'hC; key_val<=cand; armed<=0. Codes 0, D and E disarm without a pulse.
  - While key_code==F, the release counter increments. armed<=1 after RELEASE_CYC consecutive F samples.
  - Any return to a non-F code before RELEASE_CYC completes restarts the release count, and no new press is accepted.
- ENTRY state:
  - Digit with digit_cnt<DIGITS: entry<={entry[4*DIGITS-5:0],bcd}, digit_cnt++.
  - Digit with digit_cnt==DIGITS: ignored.
  - CLR: entry=0, digit_cnt=0.
  - ENT with digit_cnt==DIGITS and entry==PASSWORD: go to OPEN, fail_cnt=0, entry and digit_cnt cleared.
  - Any other ENT, including a partial entry: fail pulse, entry and digit_cnt cleared, fail_cnt++. If the new fail_cnt equals MAX_FAIL, go to ALARM and load the lockout timer.
- OPEN state: unlocked=1. Digits are ignored. CLR or ENT relocks to ENTRY. After OPEN_CYC cycles the block relocks to ENTRY automatically.
- ALARM state:
  - alarm=1 and all key events are ignored. The debouncer keeps running, so key_valid still pulses.
  - After LOCKOUT_CYC cycles: go to ENTRY, fail_cnt=0.
- Simultaneous events:
  - OPEN timeout and a key event in the same cycle: the timeout wins and the key is dropped.
  - ALARM expiry and a key event in the same cycle: the key is dropped.
- Asynchronous reset mid-operation forces all reset values immediately, including aborting OPEN or ALARM.
- Arithmetic: counters are unsigned and saturating; no wrap-around. The timer width is clog2(max(OPEN_CYC, LOCKOUT_CYC)+1).

## Timing
- key_code first sampled at edge t and held at edge t+STABLE_CYC-1: key_valid is high for the cycle following that edge.
- entry, digit_cnt and state update at the edge that samples key_valid=1, so they are visible one cycle after key_valid.
- fail asserts in that same update cycle for exactly one cycle. unlocked and alarm assert in that same update cycle.
- OPEN lasts OPEN_CYC cycles from the entry edge. ALARM lasts LOCKOUT_CYC cycles.
- All outputs are registered; there are no combinational input-to-output paths.

## Test plan
Parameters for all scenarios: STABLE_CYC=4, RELEASE_CYC=4, LOCKOUT_CYC=20, OPEN_CYC=50.
- Bounce: key_code 1,F,1,1,F,1,1,1,1,F×4 -> exactly one key_valid with key_val=1; entry=16'h0001, digit_cnt=1.
- Correct PIN: 1,2,3,4,C, each held 6 cycles with 5 F cycles between -> entry reaches 16'h1234; unlocked=1 one cycle after the ENT key_valid; auto-relock to unlocked=0 exactly 50 cycles later.
- Held key and overflow: key 5 held 40 cycles -> one event only. Then 6,7,8,9 -> entry=16'h5678 and digit_cnt=4; the 9 is ignored.
- Wrong PIN three times: 1,1,1,1,C three times -> three fail pulses; alarm=1 after the third. Keys entered during the 20 ALARM cycles leave entry=0; alarm drops after 20 cycles.
- CLR and partial ENT: 1,2,A -> entry=0. Then 3,C -> one fail pulse, fail_cnt=1.
- Reset mid-OPEN: assert sys_rst_n=0 while unlocked=1 -> unlocked, entry and digit_cnt read 0 immediately, without waiting for a clock edge.
